anton_neopixel_apb_master: RTL
==============================

// Module: anton_neopixel_apb_master
// PURPOSE
//  APB initiator that drives the neopixel controller's APB slave port (or any APB3 slave) from a simple
//  valid/ready command interface. Issues single reads and auto-incrementing write bursts (buffer fills),
//  and returns one response per command. Sits between a soft CPU/DMA/test sequencer and the neopixel APB top.
// PARAMETERS
//  MAX_LEN_BITS    13    width of cmdLen; burst of up to 2^13 bytes (whole 8192-byte pixel buffer)
//  TIMEOUT_CYCLES  255   ACCESS wait-state limit; used only when ANTON_APB_MASTER_TIMEOUT_EN is defined
// PORTS
//  apbPclk      in   1   single clock; every flop is on its rising edge
//  apbPresern   in   1   reset, asynchronous assert, active-low
//  cmdValid     in   1   command offered
//  cmdReady     out  1   command accepted when cmdValid&&cmdReady
//  cmdWrite     in   1   1=write burst, 0=single read
//  cmdAddr      in   18  byte-granular start address (control/delta/virtual/raw region in [17:16])
//  cmdWData     in   8   write data, same byte for every beat of a burst
//  cmdLen       in   MAX_LEN_BITS  beats-1 (0 = one transfer); ignored for reads
//  rspValid     out  1   one-cycle pulse when the command ends
//  rspData      out  8   read data, held until next rspValid
//  rspErr       out  1   valid with rspValid: slave error (or timeout)
//  apbPselx     out  1   APB select
//  apbPenable   out  1   APB enable
//  apbPwrite    out  1   APB direction
//  apbPaddr     out  20  {curAddr,2'b00}: word-aligned as the slave expects
//  apbPwData    out  8   APB write data
//  apbPrData    in   8   APB read data
//  apbPready    in   1   APB ready
//  apbPslverr   in   1   APB slave error
// BEHAVIOUR
//  - Reset (apbPresern=0): state IDLE; all outputs 0 except cmdReady=0 until first clock after release;
//    apbPselx/apbPenable drop asynchronously even mid-transfer; in-flight command is discarded, no response.
//  - FSM IDLE->SETUP->ACCESS->(SETUP|IDLE). cmdReady=1 only in IDLE.
//  - IDLE: accept on cmdValid; latch write/addr/data; beat counter = cmdWrite ? cmdLen : 0.
//  - SETUP (1 cycle): psel=1, penable=0; paddr/pwrite/pwdata stable from here until beat completes.
//  - ACCESS: psel=1, penable=1; remain while apbPready=0. On apbPready=1 the beat completes:
//    read -> rspData<=apbPrData; slverr sampled only on this cycle.
//  - After a completed beat: if apbPslverr=1 -> IDLE, rspValid=1, rspErr=1, remaining beats dropped;
//    else if counter==0 -> IDLE, rspValid=1, rspErr=0; else counter-1, addr+1, back to SETUP
//    (no back-to-back ACCESS; each beat = 2 cycles minimum, burst of N beats = 2N cycles + 1 accept cycle).
//  - rspValid asserted the cycle after the completing ACCESS (registered); the next command can be accepted
//    in that same cycle.
//  - Address increments modulo 2^18 (0x3FFFF+1 -> 0x00000); no wrap error flagged.
//  - apbPrData/apbPslverr ignored outside ACCESS&&apbPready; apbPready outside ACCESS ignored.
//  - cmdValid while busy is not accepted; command inputs may change freely when cmdReady=0.
// CONFIGURATION
//  ANTON_APB_MASTER_TIMEOUT_EN defined: wait counter clears on entering ACCESS, counts apbPready=0 cycles;
//    on reaching TIMEOUT_CYCLES, drop psel/penable next cycle, go IDLE, rspValid=1, rspErr=1, burst aborted.
//  Not defined: no counter synthesized; ACCESS waits indefinitely for apbPready.
// STRUCTURE
//  - anton_common.vh: FSM state encodings (IDLE/SETUP/ACCESS), APB_ADDR_SHIFT=2, default MAX_LEN_BITS
//    and TIMEOUT_CYCLES macros shared with the slave top.
//  - One sub-module: anton_apb_wait_timer (counter + expiry flag), instantiated only under the macro.
//  - Burst address/beat counters and FSM stay in the top.
// TESTING
//  1 Reset then read addr 0x00010, slave pready=1, prdata=0xA5 -> paddr=0x00040, SETUP then ACCESS,
//    rspValid 1 cycle later, rspData=0xA5, rspErr=0.
//  2 Write burst addr 0x00100 len=3 data 0x3C -> 4 beats, paddr 0x400,0x404,0x408,0x40C, pwdata=0x3C,
//    9 cycles accept-to-rspValid, rspErr=0.
//  3 Burst addr 0x3FFFE len=2 -> paddr 0xFFFF8,0xFFFFC,0x00000.
//  4 Burst len=5, pslverr=1 on beat 2 -> exactly 2 beats issued, rspErr=1, FSM IDLE, cmdReady=1.
//  5 Slave pready low 3 cycles -> signals held stable, ACCESS lasts 4 cycles; with TIMEOUT_EN and
//    TIMEOUT_CYCLES=4, pready held low 10 cycles -> abort after 4 wait cycles, rspErr=1.
//  6 Assert apbPresern=0 mid-burst -> psel/penable 0 same cycle, no rspValid, fresh command works after.

Source files
------------

// File: rtl/anton_neopixel_apb_master_pkg.sv
// Shared definitions for the neopixel APB initiator: FSM encoding, address geometry and defaults.
// The wait-state timeout is built only when ANTON_APB_MASTER_TIMEOUT_EN is defined.
package anton_neopixel_apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    localparam int unsigned APB_ADDR_SHIFT         = 2;
    localparam int unsigned CMD_ADDR_W             = 18;
    localparam int unsigned APB_ADDR_W             = CMD_ADDR_W + APB_ADDR_SHIFT;
    localparam int unsigned DEFAULT_MAX_LEN_BITS   = 13;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    // The slave decodes word addresses, so the byte index sits above two zero bits.
    function automatic logic [APB_ADDR_W-1:0] to_apb_addr(input logic [CMD_ADDR_W-1:0] addr);
        return {addr, {APB_ADDR_SHIFT{1'b0}}};
    endfunction

endpackage

// File: rtl/anton_neopixel_apb_master_wait_timer.sv
// ACCESS wait-state counter with expiry flag; exists only when ANTON_APB_MASTER_TIMEOUT_EN is defined.
`ifdef ANTON_APB_MASTER_TIMEOUT_EN
module anton_neopixel_apb_master_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic wait_en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // expired fires on the wait cycle that would make the count reach TIMEOUT_CYCLES.
    assign expired = wait_en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (wait_en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/anton_neopixel_apb_master.sv
// APB3 initiator: single reads and auto-incrementing write bursts from a valid/ready command port.
// Optional ACCESS wait-state timeout is enabled by defining ANTON_APB_MASTER_TIMEOUT_EN.
module anton_neopixel_apb_master
    import anton_neopixel_apb_master_pkg::*;
#(
    parameter int unsigned MAX_LEN_BITS   = DEFAULT_MAX_LEN_BITS,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    apbPclk,
    input  logic                    apbPresern,
    input  logic                    cmdValid,
    output logic                    cmdReady,
    input  logic                    cmdWrite,
    input  logic [CMD_ADDR_W-1:0]   cmdAddr,
    input  logic [7:0]              cmdWData,
    input  logic [MAX_LEN_BITS-1:0] cmdLen,
    output logic                    rspValid,
    output logic [7:0]              rspData,
    output logic                    rspErr,
    output logic                    apbPselx,
    output logic                    apbPenable,
    output logic                    apbPwrite,
    output logic [APB_ADDR_W-1:0]   apbPaddr,
    output logic [7:0]              apbPwData,
    input  logic [7:0]              apbPrData,
    input  logic                    apbPready,
    input  logic                    apbPslverr,
    output logic [1:0]              dbgState
);

    // Command handshake: a command is taken on the rising edge where cmdValid && cmdReady;
    // cmdReady is high only in IDLE, and command inputs are don't-care whenever cmdReady is low.

    apb_state_e              state_q;
    apb_state_e              state_d;
    logic                    init_q;
    logic                    init_d;
    logic                    write_q;
    logic                    write_d;
    logic [CMD_ADDR_W-1:0]   addr_q;
    logic [CMD_ADDR_W-1:0]   addr_d;
    logic [7:0]              wdata_q;
    logic [7:0]              wdata_d;
    logic [MAX_LEN_BITS-1:0] beats_q;
    logic [MAX_LEN_BITS-1:0] beats_d;
    logic                    rsp_valid_q;
    logic                    rsp_valid_d;
    logic                    rsp_err_q;
    logic                    rsp_err_d;
    logic [7:0]              rsp_data_q;
    logic [7:0]              rsp_data_d;

    logic accept;
    logic beat_done;
    logic last_beat;
    logic timeout_hit;

    assign accept    = (state_q == ST_IDLE) && init_q && cmdValid;
    assign beat_done = (state_q == ST_ACCESS) && apbPready;
    assign last_beat = (beats_q == '0);

`ifdef ANTON_APB_MASTER_TIMEOUT_EN
    anton_neopixel_apb_master_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (apbPclk),
        .rst_n   (apbPresern),
        .clear   (state_q == ST_SETUP),
        .wait_en ((state_q == ST_ACCESS) && !apbPready),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // State register: reset drops state to IDLE immediately, which also drops psel/penable.
    always_ff @(posedge apbPclk or negedge apbPresern) begin
        if (!apbPresern) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (beat_done) begin
                    state_d = (apbPslverr || last_beat) ? ST_IDLE : ST_SETUP;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        init_d      = 1'b1;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        beats_d     = beats_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;

        if (accept) begin
            write_d = cmdWrite;
            addr_d  = cmdAddr;
            wdata_d = cmdWData;
            beats_d = cmdWrite ? cmdLen : '0;
        end

        if (beat_done) begin
            if (!write_q) begin
                rsp_data_d = apbPrData;
            end
            if (apbPslverr) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
            end else if (last_beat) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
            end else begin
                beats_d = beats_q - MAX_LEN_BITS'(1);
                addr_d  = addr_q + CMD_ADDR_W'(1);
            end
        end else if ((state_q == ST_ACCESS) && timeout_hit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge apbPclk or negedge apbPresern) begin
        if (!apbPresern) begin
            init_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            beats_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            init_q      <= init_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            beats_q     <= beats_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // init_q keeps cmdReady low until the first clock edge after reset release.
    always_comb begin
        cmdReady   = (state_q == ST_IDLE) && init_q;
        apbPselx   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
        apbPenable = (state_q == ST_ACCESS);
        apbPwrite  = write_q;
        apbPaddr   = to_apb_addr(addr_q);
        apbPwData  = wdata_q;
        rspValid   = rsp_valid_q;
        rspErr     = rsp_err_q;
        rspData    = rsp_data_q;
        dbgState   = state_q;
    end

endmodule
